jtframe_sdram_sched: RTL and testbench

//  Arbitrates one SDRAM read port among NREQ ROM-slot requesters. Fixed priority (req[0] highest),

---
 rtl/jtframe_sched_pkg.sv | 12 +
 rtl/jtframe_sched_pick.sv | 33 +++
 rtl/jtframe_sdram_sched.sv | 139 +++++++++++++
 tb/tb_jtframe_sdram_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sched_pkg.sv
// Shared types for the SDRAM read-port scheduler and its priority picker.
package jtframe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int DEF_AW = 22;

endpackage

// File: rtl/jtframe_sched_pick.sv
// Combinational fixed-priority picker: lowest-index aged requester first,
// otherwise lowest-index requester. Returns one-hot and binary forms.
module jtframe_sched_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  aged,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] cand_s;

    // Scan from the top so the lowest set candidate is the last one written
    always_comb begin
        cand_s = ((req & aged) != '0) ? (req & aged) : req;
        onehot = '0;
        idx    = '0;
        valid  = (req != '0);
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                onehot = N'(1) << i;
                idx    = IW'(i);
            end else begin
                onehot = onehot;
                idx    = idx;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_sched.sv
// Arbitrates one SDRAM read port among NREQ ROM slots with age-based promotion,
// owns the req/ack/data_rdy handshake and aborts transfers whose data never returns.
module jtframe_sdram_sched
    import jtframe_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = DEF_AW,
    parameter int AGEW    = 4,
    parameter int AGE_MAX = 12,
    parameter int TOW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]   sel,
    output logic              sdram_req,
    output logic [AW-1:0]     sdram_addr,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    output logic              busy,
    output logic              err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AGEW-1:0] AGE_SAT = {AGEW{1'b1}};
    // Stepping out of this value lands on all-ones, which is the abort point
    localparam logic [TOW-1:0]  TOUT_LAST = {{(TOW-1){1'b1}}, 1'b0};

    state_t              state_r;
    logic [NREQ-1:0]     sel_r;
    logic                sdram_req_r;
    logic [AW-1:0]       sdram_addr_r;
    logic                err_r;
    logic [TOW-1:0]      tout_r;
    logic [AGEW-1:0]     age_r [NREQ];

    logic [NREQ-1:0]     aged_s;
    logic [NREQ-1:0]     win_oh_s;
    logic [IW-1:0]       win_idx_s;
    logic                win_vld_s;
    logic                grant_s;
    logic                busy_s;
    logic [AW-1:0]       slot_addr_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot_addr_s[g] = addr[g*AW +: AW];
        assign aged_s[g]      = (age_r[g] >= AGEW'(AGE_MAX));
    end

    jtframe_sched_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .aged   (aged_s),
        .onehot (win_oh_s),
        .idx    (win_idx_s),
        .valid  (win_vld_s)
    );

    assign busy_s  = (state_r != IDLE);
    assign grant_s = (state_r == IDLE) && win_vld_s;

    // Age counters: cleared when idle-requesting stops or on grant, frozen while being served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) age_r[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || (grant_s && win_oh_s[i])) begin
                    age_r[i] <= '0;
                end else if (busy_s && sel_r[i]) begin
                    age_r[i] <= age_r[i];
                end else if (age_r[i] != AGE_SAT) begin
                    age_r[i] <= age_r[i] + AGEW'(1);
                end else begin
                    age_r[i] <= age_r[i];
                end
            end
        end
    end

    // Handshake FSM; sel and sdram_addr only ever change on the IDLE grant or on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= '0;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= '0;
            err_r        <= 1'b0;
            tout_r       <= '0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_vld_s) begin
                        sel_r        <= win_oh_s;
                        sdram_addr_r <= slot_addr_s[win_idx_s];
                        sdram_req_r  <= 1'b1;
                        state_r      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        tout_r      <= '0;
                        if (data_rdy) begin
                            state_r <= IDLE;
                            sel_r   <= '0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    tout_r <= tout_r + TOW'(1);
                    if (data_rdy) begin
                        state_r <= IDLE;
                        sel_r   <= '0;
                    end else if (tout_r == TOUT_LAST) begin
                        state_r <= IDLE;
                        sel_r   <= '0;
                        err_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    sel_r       <= '0;
                    sdram_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign sdram_req  = sdram_req_r;
    assign sdram_addr = sdram_addr_r;
    assign err        = err_r;
    assign busy       = busy_s;

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// Bench for jtframe_sdram_sched: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_jtframe_sdram_sched;

    localparam int NREQ = 4;
    localparam int AW   = 22;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ-1:0]      sel;
    logic                 sdram_req;
    logic [AW-1:0]        sdram_addr;
    logic                 ack;
    logic                 rdy;
    logic                 busy;
    logic                 err;

    int n_vec = 0;
    int n_bad = 0;

    jtframe_sdram_sched #(.NREQ(NREQ), .AW(AW), .AGEW(4), .AGE_MAX(12), .TOW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr       (addr),
        .sel        (sel),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (ack),
        .data_rdy   (rdy),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 request outstanding, 2 waiting for data
    typedef struct packed {
        int                   ph;
        int                   slot;
        logic [AW-1:0]        addr;
        logic [NREQ-1:0][7:0] age;
        int                   waited;
        logic                 err;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r = '0;
        r.slot = -1;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, logic [NREQ-1:0] r, logic [NREQ*AW-1:0] a,
                                  logic k, logic d);
        mdl_t n = c;
        int w = -1;
        n.err = 1'b0;
        if (c.ph == 0) begin
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && r[i] && c.age[i] >= 12) w = i;
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && r[i]) w = i;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!r[i] || i == w) n.age[i] = 8'd0;
            else if (c.ph != 0 && i == c.slot) n.age[i] = c.age[i];
            else n.age[i] = (c.age[i] >= 8'd15) ? 8'd15 : c.age[i] + 8'd1;
        end
        if (c.ph == 0) begin
            if (w >= 0) begin
                n.ph = 1; n.slot = w; n.addr = a[w*AW +: AW];
            end
        end else if (c.ph == 1) begin
            if (k && d) begin
                n.ph = 0; n.slot = -1;
            end else if (k) begin
                n.ph = 2; n.waited = 0;
            end
        end else begin
            if (d) begin
                n.ph = 0; n.slot = -1;
            end else begin
                n.waited = c.waited + 1;
                if (n.waited == 63) begin
                    n.ph = 0; n.slot = -1; n.err = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= mdl_reset();
        else     m <= step(m, req, addr, ack, rdy);
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [NREQ-1:0] es;
        es = '0;
        if (m.slot >= 0) es[m.slot] = 1'b1;
        chk("sel", 64'(sel), 64'(es));
        chk("sdram_req", 64'(sdram_req), 64'(m.ph == 1));
        chk("sdram_addr", 64'(sdram_addr), 64'(m.addr));
        chk("busy", 64'(busy), 64'(m.ph != 0));
        chk("err", 64'(err), 64'(m.err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_addr(input int i, input logic [AW-1:0] v);
        addr[i*AW +: AW] = v;
    endtask

    task automatic wait_req(output logic [NREQ-1:0] s, output logic [AW-1:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sdram_req && n < 30);
        chk("req_wait", 64'(sdram_req), 64'd1);
        s = sel;
        a = sdram_addr;
    endtask

    task automatic xfer(input int ad, input int rd, input bit drop,
                        output logic [NREQ-1:0] s, output logic [AW-1:0] a);
        wait_req(s, a);
        repeat (ad) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (rd) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        if (drop) req = req & ~s;
    endtask

    localparam logic [AW-1:0] A0 = 22'h011111;
    localparam logic [AW-1:0] A1 = 22'h022222;
    localparam logic [AW-1:0] A2 = 22'h033333;
    localparam logic [AW-1:0] A3 = 22'h3F0F0F;
    localparam logic [AW-1:0] A2B = 22'h155AA5;

    initial begin
        logic [NREQ-1:0] s;
        logic [AW-1:0]   a;
        int              n;
        req = '0; ack = 1'b0; rdy = 1'b0; addr = '0;
        set_addr(0, A0); set_addr(1, A1); set_addr(2, A2); set_addr(3, A3);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_sdram_req", 64'(sdram_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // 1: two simultaneous requests served in index order
        req = 4'b0110;
        xfer(2, 3, 1'b1, s, a);
        chk("t1_sel_a", 64'(s), 64'b0010);
        chk("t1_addr_a", 64'(a), 64'(A1));
        xfer(1, 0, 1'b1, s, a);
        chk("t1_sel_b", 64'(s), 64'b0100);
        chk("t1_addr_b", 64'(a), 64'(A2));
        @(negedge clk);

        // 2: slot 3 ages past slot 0 on the third grant
        req = 4'b1001;
        xfer(1, 2, 1'b0, s, a);
        chk("t2_g1", 64'(s), 64'b0001);
        xfer(1, 2, 1'b0, s, a);
        chk("t2_g2", 64'(s), 64'b0001);
        xfer(1, 2, 1'b1, s, a);
        chk("t2_g3_aged", 64'(s), 64'b1000);
        chk("t2_addr3", 64'(a), 64'(A3));
        xfer(0, 0, 1'b1, s, a);
        chk("t2_g4", 64'(s), 64'b0001);
        @(negedge clk);

        // 3: data never returns -> abort after 63 waiting cycles, then retry
        req = 4'b0100;
        wait_req(s, a);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err && n < 80);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_wait_cycles", 64'(n), 64'd63);
        chk("t3_sel", 64'(sel), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        xfer(0, 0, 1'b1, s, a);
        chk("t3_regrant", 64'(s), 64'b0100);
        @(negedge clk);

        // 4: ack and data in the same cycle
        req = 4'b0001;
        wait_req(s, a);
        ack = 1'b1; rdy = 1'b1;
        @(negedge clk);
        ack = 1'b0; rdy = 1'b0; req = '0;
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_sdram_req", 64'(sdram_req), 64'd0);
        chk("t4_err", 64'(err), 64'd0);
        @(negedge clk);

        // 5: reset while waiting for data, then stray handshake inputs
        req = 4'b0010;
        wait_req(s, a);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_sel", 64'(sel), 64'd0);
        chk("t5_sdram_req", 64'(sdram_req), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        req = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) begin rdy = 1'b1; ack = 1'b1; end
        @(negedge clk) begin rdy = 1'b0; ack = 1'b0; end
        chk("t5_stray_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // 6: address of the served slot changes mid-transfer
        req = 4'b0100;
        wait_req(s, a);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        set_addr(2, A2B);
        repeat (3) @(negedge clk);
        chk("t6_addr_held", 64'(sdram_addr), 64'(A2));
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        xfer(0, 1, 1'b1, s, a);
        chk("t6_addr_new", 64'(a), 64'(A2B));
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
